// File: rtl/branch_flag_pkg.sv
// Shared types and constants for the branch flag unit.
// State encoding, datapath width and RISC-V branch funct3 codes.
package branch_flag_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/flag_slice_add.sv
// One W-bit adder slice with carry-in and carry-out, chained serially by the
// branch flag unit.
module flag_slice_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/branch_flag_unit.sv
// Computes cf/zf/vf/sf of op_a - op_b for branch resolution, serially one
// SLICE_W slice per cycle; define FLAG_SINGLE_CYCLE_EN for a one-cycle subtract.
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high; valid holds its payload stable until that edge.
module branch_flag_unit
   import branch_flag_pkg::*;
#(
   parameter int SLICE_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [2:0]      funct3_in,
   input  logic            branch_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            cf,
   output logic            zf,
   output logic            vf,
   output logic            sf,
   output logic [2:0]      funct3_out,
   output logic            branch_out,
   output state_t          state_dbg
);

`ifdef FLAG_SINGLE_CYCLE_EN
   localparam int ADD_W = XLEN;
`else
   localparam int ADD_W = SLICE_W;
`endif
   localparam int NSLICE = XLEN / ADD_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   state_t            state_q, state_d;
   logic [XLEN-1:0]   a_q, b_q, diff_q, diff_full;
   logic [2:0]        f3_q;
   logic              br_q, carry_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              cf_q, zf_q, vf_q, sf_q;
   logic              accept;
   logic [ADD_W-1:0]  slice_a, slice_b, slice_sum;
   logic              slice_cout;

   // Inverted rs2 slice plus the carry register (seeded with 1) forms a - b.
   always_comb begin
      slice_a = a_q[int'(cnt_q) * ADD_W +: ADD_W];
      slice_b = ~b_q[int'(cnt_q) * ADD_W +: ADD_W];
   end

   flag_slice_add #(.W(ADD_W)) u_add (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      diff_full = diff_q;
      diff_full[int'(cnt_q) * ADD_W +: ADD_W] = slice_sum;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: in_ready = 1'b1;
         CALC: if (cnt_q == LAST) state_d = DONE;
         DONE: begin
            in_ready = out_ready;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      accept = in_valid && in_ready && !flush;
      if (accept) state_d = CALC;
      if (flush)  state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         f3_q    <= '0;
         br_q    <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         cf_q    <= 1'b0;
         zf_q    <= 1'b0;
         vf_q    <= 1'b0;
         sf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            f3_q    <= funct3_in;
            br_q    <= branch_in;
            cnt_q   <= '0;
            carry_q <= 1'b1;
         end else if (state_q == CALC && !flush) begin
            diff_q  <= diff_full;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + 1'b1;
            // Flags are latched only once the top slice has been summed.
            if (cnt_q == LAST) begin
               cf_q <= slice_cout;
               zf_q <= (diff_full == '0);
               sf_q <= diff_full[XLEN-1];
               vf_q <= (a_q[XLEN-1] != b_q[XLEN-1]) && (diff_full[XLEN-1] != a_q[XLEN-1]);
            end
         end
      end
   end

   assign out_valid  = (state_q == DONE);
   assign cf         = cf_q;
   assign zf         = zf_q;
   assign vf         = vf_q;
   assign sf         = sf_q;
   assign funct3_out = f3_q;
   assign branch_out = br_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Bench for branch_flag_unit: reference model of the handshake/latency and
// flag arithmetic, checked every cycle, plus directed literal vectors.
module tb_branch_flag_unit;
   import branch_flag_pkg::*;

   localparam int SLICE_W = 8;
`ifdef FLAG_SINGLE_CYCLE_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 4;
`endif
   localparam int RW  = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [2:0]  funct3_in = '0;
   logic        branch_in = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        cf, zf, vf, sf;
   logic [2:0]  funct3_out;
   logic        branch_out;
   state_t      state_dbg;

   int checks = 0;
   int errors = 0;

   logic [RW-1:0] exp_q[$];
   int            m_pending = 0;
   bit            m_valid = 1'b0;
   bit            m_after_rst = 1'b0;
   bit            m_known = 1'b0;
   logic [RW-1:0] m_exp = '0;

   branch_flag_unit #(.SLICE_W(SLICE_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .funct3_in  (funct3_in),
      .branch_in  (branch_in),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .cf         (cf),
      .zf         (zf),
      .vf         (vf),
      .sf         (sf),
      .funct3_out (funct3_out),
      .branch_out (branch_out),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // {cf, zf, vf, sf} from ordinary unsigned and sign-extended arithmetic
   function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      logic [32:0] sd;
      d  = a - b;
      sd = {a[31], a} - {b[31], b};
      return {a >= b, a == b, sd[32] ^ sd[31], d[31]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model, advanced on each rising edge
   always @(posedge clk) begin
      bit rdy, acc;
      if (rst) begin
         m_known = 1'b1; m_pending = 0; m_valid = 1'b0; m_after_rst = 1'b1;
         m_exp = '0; exp_q.delete();
      end else if (flush) begin
         m_pending = 0; m_valid = 1'b0; exp_q.delete();
      end else if (m_known) begin
         rdy = (!m_valid && m_pending == 0) || (m_valid && out_ready);
         acc = in_valid && rdy;
         if (m_valid && out_ready) m_valid = 1'b0;
         if (m_pending > 0) begin
            m_pending--;
            if (m_pending == 0 && exp_q.size() > 0) begin
               m_exp = exp_q.pop_front();
               m_valid = 1'b1;
            end
         end
         if (acc) begin
            m_pending = LAT;
            m_after_rst = 1'b0;
            exp_q.push_back({ref_flags(op_a, op_b), funct3_in, branch_in});
         end
      end
   end

   // scoreboard compare on the falling edge
   always @(negedge clk) begin
      if (m_known) begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("in_ready", 32'(in_ready),
             32'((!m_valid && m_pending == 0) || (m_valid && out_ready)));
         if (m_valid)
            chk("result", 32'({cf, zf, vf, sf, funct3_out, branch_out}), 32'(m_exp));
         else if (m_after_rst)
            chk("reset_outputs", 32'({cf, zf, vf, sf, funct3_out, branch_out}), 32'd0);
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3, input logic br);
      in_valid = 1'b1; op_a = a; op_b = b; funct3_in = f3; branch_in = br;
      tick();
      in_valid = 1'b0;
      op_a = $urandom; op_b = $urandom;
      funct3_in = 3'($urandom_range(0, 7)); branch_in = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         tick();
         cyc++;
         op_a = $urandom; op_b = $urandom;
      end
      if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic lit_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic br, input logic [3:0] exp_flags);
      int cyc;
      send(a, b, f3, br);
      wait_valid(cyc);
      chk("latency", 32'(cyc), 32'(LAT));
      chk("flags_lit", 32'({cf, zf, vf, sf}), 32'(exp_flags));
      chk("funct3_lit", 32'(funct3_out), 32'(f3));
      chk("branch_lit", 32'(branch_out), 32'(br));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int cyc;
      tick(); tick();
      rst = 1'b0;
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_ready", 32'(in_ready), 32'd1);

      lit_op(32'd5, 32'd5, BEQ, 1'b1, 4'b1100);
      lit_op(32'h8000_0000, 32'd1, BLT, 1'b1, 4'b1010);
      lit_op(32'd1, 32'd2, BLTU, 1'b1, 4'b0001);
      lit_op(32'd0, 32'd0, BGE, 1'b0, 4'b1100);
      lit_op(32'hFFFF_FFFF, 32'd0, BGEU, 1'b1, 4'b1001);
      lit_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, BNE, 1'b1, 4'b0011);

      // stall in DONE, then back-to-back accept
      send(32'h10, 32'h20, BLT, 1'b1);
      wait_valid(cyc);
      repeat (3) begin
         tick();
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk("stall_flags", 32'({cf, zf, vf, sf}), 32'b0001);
      end
      in_valid = 1'b1; op_a = 32'd3; op_b = 32'd3; funct3_in = BEQ; branch_in = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0; op_a = $urandom; op_b = $urandom;
      chk("b2b_state", 32'(state_dbg), 32'(CALC));
      wait_valid(cyc);
      chk("b2b_flags", 32'({cf, zf, vf, sf}), 32'b1100);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // flush during CALC with a competing request
      send(32'd9, 32'd4, BNE, 1'b1);
      tick();
      flush = 1'b1; in_valid = 1'b1; op_a = 32'd7; op_b = 32'd7;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_state", 32'(state_dbg), 32'(IDLE));
      repeat (6) tick();
      chk("flush_dropped", 32'(out_valid), 32'd0);

      // reset while holding a result in DONE
      send(32'd1, 32'd2, BLTU, 1'b1);
      wait_valid(cyc);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_done_outputs", 32'({out_valid, cf, zf, vf, sf, funct3_out, branch_out}), 32'd0);

      lit_op(32'd100, 32'd7, BGE, 1'b0, 4'b1000);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
